// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FWFT/standard FIFO.
// Provides clog2_safe and the packed status word used for register mapping.
package fifo_pkg;

    // Address width for a storage of n entries, never narrower than 1 bit.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_sync_fwft_if.sv
// Producer/consumer bundle for fifo_sync_fwft.
// master: drives wr_en/din/rd_en/clear_flags; slave: drives data, count, flags.
interface fifo_sync_fwft_if #(
    parameter int DATA_WIDTH = 68,
    parameter int LOGDEPTH   = 7
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic                  clear_flags;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [LOGDEPTH:0]     count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, din, rd_en, clear_flags,
        input  dout, empty, full, almost_empty, almost_full,
        input  count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clear_flags,
        output dout, empty, full, almost_empty, almost_full,
        output count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram_sdp.sv
// Single-clock simple dual-port RAM: synchronous write, async or registered read.
// Ports: clk, rst (read register only), we/waddr/wdata, re/raddr, rdata.
module fifo_ram_sdp
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 68,
    parameter int  DEPTH      = 128,
    parameter bit  ASYNC_RD   = 1'b1,
    localparam int AW         = clog2_safe(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Contents are intentionally never reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (ASYNC_RD) begin : g_async
            logic unused_rd;
            assign unused_rd = ^{re, rst};
            assign rdata = mem[raddr];
        end else begin : g_sync
            logic [DATA_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO with FWFT or registered read, occupancy count, thresholds.
// Ports: clk, rst (sync, active-high), bus (slave side of fifo_sync_fwft_if).
module fifo_sync_fwft
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH    = 68,
    parameter int  LOGDEPTH      = 7,
    localparam int DEPTH         = 2 ** LOGDEPTH,
    parameter int  AFULL_THRESH  = DEPTH - 4,
    parameter int  AEMPTY_THRESH = 4,
    parameter bit  FWFT          = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    fifo_sync_fwft_if.slave  bus
);

    localparam int CNT_W = LOGDEPTH + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AEMPTY_THRESH);

    logic [LOGDEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOGDEPTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    fifo_status_t          st_q, st_d;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        wr_acc   = bus.wr_en & ~st_q.full;
        rd_acc   = bus.rd_en & ~st_q.empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Power-of-two depth: pointers wrap by natural overflow.
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end

        // Flags track the next count so they never lag it.
        st_d.empty        = (count_d == '0);
        st_d.full         = (count_d == CNT_FULL);
        st_d.almost_empty = (count_d <= AE_LVL);
        st_d.almost_full  = (count_d >= AF_LVL);

        // A new error event wins over a same-cycle clear.
        st_d.overflow  = (bus.wr_en & st_q.full) |
                         (st_q.overflow & ~bus.clear_flags);
        st_d.underflow = (bus.rd_en & st_q.empty) |
                         (st_q.underflow & ~bus.clear_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            st_q     <= '{empty: 1'b1, full: 1'b0,
                          almost_empty: 1'b1, almost_full: 1'b0,
                          overflow: 1'b0, underflow: 1'b0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            st_q     <= st_d;
        end
    end

    fifo_ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ASYNC_RD   (FWFT)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q),
        .wdata (bus.din),
        .re    (rd_acc & ~rst),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // In FWFT mode the head word is gated to zero while nothing is stored.
    assign bus.dout = (FWFT && st_q.empty) ? '0 : ram_rdata;

    assign bus.empty        = st_q.empty;
    assign bus.full         = st_q.full;
    assign bus.almost_empty = st_q.almost_empty;
    assign bus.almost_full  = st_q.almost_full;
    assign bus.overflow     = st_q.overflow;
    assign bus.underflow    = st_q.underflow;
    assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Self-checking bench for fifo_sync_fwft: FWFT instance plus standard-mode instance.
// Scoreboard queues hold expected words; counts and flags come from a small model.
module tb_fifo_sync_fwft;

    localparam int DW    = 68;
    localparam int LD    = 7;
    localparam int DEPTH = 128;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_sync_fwft_if #(.DATA_WIDTH(DW), .LOGDEPTH(LD)) a ();
    fifo_sync_fwft_if #(.DATA_WIDTH(DW), .LOGDEPTH(LD)) b ();

    fifo_sync_fwft #(.DATA_WIDTH(DW), .LOGDEPTH(LD), .FWFT(1'b1)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    fifo_sync_fwft #(.DATA_WIDTH(DW), .LOGDEPTH(LD), .FWFT(1'b0)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    int            m_count = 0;
    bit            m_ovf   = 0;
    bit            m_udf   = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] sbb [$];

    task automatic model_reset();
        m_count = 0;
        m_ovf   = 0;
        m_udf   = 0;
        sb.delete();
    endtask

    task automatic drive(input bit w, input logic [DW-1:0] d,
                         input bit r, input bit clr);
        bit wa, ra;
        a.wr_en = w; a.din = d; a.rd_en = r; a.clear_flags = clr;
        wa = w && (m_count < DEPTH);
        ra = r && (m_count > 0);
        m_ovf = (w && m_count == DEPTH) || (m_ovf && !clr);
        m_udf = (r && m_count == 0) || (m_udf && !clr);
        if (ra) void'(sb.pop_front());
        if (wa) sb.push_back(d);
        m_count = m_count + int'(wa) - int'(ra);
        @(posedge clk); #1;
        a.wr_en = 0; a.rd_en = 0; a.clear_flags = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        n_total++; if (a.count !== 8'd0) $display("FAIL rst_count got %0d want 0", a.count); else n_pass++;
        n_total++; if (a.empty !== 1'b1) $display("FAIL rst_empty got %b want 1", a.empty); else n_pass++;
        n_total++; if (a.full !== 1'b0) $display("FAIL rst_full got %b want 0", a.full); else n_pass++;
        n_total++; if (a.almost_empty !== 1'b1) $display("FAIL rst_aempty got %b want 1", a.almost_empty); else n_pass++;
        n_total++; if (a.almost_full !== 1'b0) $display("FAIL rst_afull got %b want 0", a.almost_full); else n_pass++;
        n_total++; if (a.overflow !== 1'b0 || a.underflow !== 1'b0) $display("FAIL rst_err got %b%b want 00", a.overflow, a.underflow); else n_pass++;
        n_total++; if (a.dout !== '0) $display("FAIL rst_dout got %h want 0", a.dout); else n_pass++;
        n_total++; if (b.dout !== '0) $display("FAIL rst_dout_std got %h want 0", b.dout); else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, DW'(i), 0, 0);
            n_total++; if (a.count !== CW'(m_count)) $display("FAIL fill_count got %0d want %0d", a.count, m_count); else n_pass++;
            n_total++; if (a.almost_empty !== (m_count <= 4)) $display("FAIL fill_aempty cnt %0d got %b", m_count, a.almost_empty); else n_pass++;
            n_total++; if (a.almost_full !== (m_count >= 124)) $display("FAIL fill_afull cnt %0d got %b", m_count, a.almost_full); else n_pass++;
            n_total++; if (a.full !== (m_count == DEPTH)) $display("FAIL fill_full cnt %0d got %b", m_count, a.full); else n_pass++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_total++; if (a.dout !== sb[0]) $display("FAIL drain_data got %h want %h", a.dout, sb[0]); else n_pass++;
            drive(0, '0, 1, 0);
            n_total++; if (a.count !== CW'(m_count)) $display("FAIL drain_count got %0d want %0d", a.count, m_count); else n_pass++;
        end
        n_total++; if (a.empty !== 1'b1) $display("FAIL drain_empty got %b want 1", a.empty); else n_pass++;
        n_total++; if (a.dout !== '0) $display("FAIL drain_dout got %h want 0", a.dout); else n_pass++;
        n_total++; if (a.underflow !== 1'b0) $display("FAIL drain_udf got %b want 0", a.underflow); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) drive(1, DW'(32'h100 + i), 0, 0);
        drive(1, DW'(16'hDEAD), 0, 0);
        n_total++; if (a.count !== CW'(m_count)) $display("FAIL ovf_count got %0d want %0d", a.count, m_count); else n_pass++;
        n_total++; if (a.overflow !== m_ovf) $display("FAIL ovf_flag got %b want %b", a.overflow, m_ovf); else n_pass++;
        drive(1, DW'(16'hBEEF), 1, 0);
        n_total++; if (a.count !== CW'(m_count)) $display("FAIL ovf_rw_count got %0d want %0d", a.count, m_count); else n_pass++;
        drive(0, '0, 0, 1);
        n_total++; if (a.overflow !== m_ovf) $display("FAIL ovf_clear got %b want %b", a.overflow, m_ovf); else n_pass++;
        while (m_count > 0) begin
            n_total++; if (a.dout !== sb[0]) $display("FAIL ovf_data got %h want %h", a.dout, sb[0]); else n_pass++;
            drive(0, '0, 1, 0);
        end
        n_total++; if (a.empty !== 1'b1) $display("FAIL ovf_empty got %b want 1", a.empty); else n_pass++;
    endtask

    task automatic test_underflow();
        drive(1, DW'(5), 1, 0);
        n_total++; if (a.underflow !== m_udf) $display("FAIL udf_flag got %b want %b", a.underflow, m_udf); else n_pass++;
        n_total++; if (a.count !== CW'(m_count)) $display("FAIL udf_count got %0d want %0d", a.count, m_count); else n_pass++;
        n_total++; if (a.dout !== sb[0]) $display("FAIL udf_dout got %h want %h", a.dout, sb[0]); else n_pass++;
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 1);
        n_total++; if (a.underflow !== m_udf) $display("FAIL udf_setwins got %b want %b", a.underflow, m_udf); else n_pass++;
        drive(0, '0, 0, 1);
        n_total++; if (a.underflow !== m_udf) $display("FAIL udf_clear got %b want %b", a.underflow, m_udf); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) drive(1, DW'($urandom), 0, 0);
        for (int i = 0; i < 200; i++) begin
            n_total++; if (a.dout !== sb[0]) $display("FAIL b2b_data got %h want %h", a.dout, sb[0]); else n_pass++;
            drive(1, {4'hA, 32'($urandom), 32'($urandom)}, 1, 0);
            n_total++; if (a.count !== 8'd60 || a.full !== 1'b0 || a.empty !== 1'b0) $display("FAIL b2b_level got cnt %0d f%b e%b want 60 f0 e0", a.count, a.full, a.empty); else n_pass++;
        end
        while (m_count > 0) drive(0, '0, 1, 0);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 90; i++) drive(1, DW'(i + 7), 0, 0);
        n_total++; if (a.count !== 8'd90) $display("FAIL mrst_pre got %0d want 90", a.count); else n_pass++;
        rst = 1; a.wr_en = 1; a.rd_en = 1; a.din = DW'(9);
        @(posedge clk); #1;
        rst = 0; a.wr_en = 0; a.rd_en = 0;
        model_reset();
        n_total++; if (a.count !== 8'd0 || a.empty !== 1'b1 || a.full !== 1'b0) $display("FAIL mrst_cnt got %0d e%b f%b want 0 e1 f0", a.count, a.empty, a.full); else n_pass++;
        n_total++; if (a.almost_empty !== 1'b1 || a.almost_full !== 1'b0) $display("FAIL mrst_alm got ae%b af%b want ae1 af0", a.almost_empty, a.almost_full); else n_pass++;
        n_total++; if (a.overflow !== 1'b0 || a.underflow !== 1'b0 || a.dout !== '0) $display("FAIL mrst_misc got o%b u%b d%h want 0", a.overflow, a.underflow, a.dout); else n_pass++;
    endtask

    task automatic test_std_mode();
        logic [DW-1:0] exp;
        logic [DW-1:0] last;
        b.wr_en = 1; b.din = DW'(4'hA); sbb.push_back(DW'(4'hA));
        @(posedge clk); #1;
        b.din = DW'(4'hB); sbb.push_back(DW'(4'hB));
        @(posedge clk); #1;
        b.wr_en = 0;
        n_total++; if (b.dout !== '0) $display("FAIL std_prefetch got %h want 0", b.dout); else n_pass++;
        b.rd_en = 1; exp = sbb.pop_front();
        @(posedge clk); #1;
        b.rd_en = 0;
        n_total++; if (b.dout !== exp) $display("FAIL std_read1 got %h want %h", b.dout, exp); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (b.dout !== exp) $display("FAIL std_hold got %h want %h", b.dout, exp); else n_pass++;
        b.rd_en = 1; exp = sbb.pop_front();
        @(posedge clk); #1;
        n_total++; if (b.dout !== exp) $display("FAIL std_read2 got %h want %h", b.dout, exp); else n_pass++;
        last = exp;
        @(posedge clk); #1;
        b.rd_en = 0;
        n_total++; if (b.dout !== last) $display("FAIL std_rejhold got %h want %h", b.dout, last); else n_pass++;
        n_total++; if (b.underflow !== 1'b1 || b.empty !== 1'b1) $display("FAIL std_udf got u%b e%b want u1 e1", b.underflow, b.empty); else n_pass++;
    endtask

    initial begin
        a.wr_en = 0; a.rd_en = 0; a.clear_flags = 0; a.din = '0;
        b.wr_en = 0; b.rd_en = 0; b.clear_flags = 0; b.din = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_mid_reset();
        test_std_mode();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_sync_fwft.md
# fifo_sync_fwft

Single-clock, parametrised FIFO: the same-domain successor to the dual-clock RTIO event FIFO, for buffers where producer and consumer share `clk`. Adds a selectable read mode (first-word-fall-through or registered one-cycle latency), a live occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow and underflow error flags. It sits between RTIO event producers and the output serialiser, which uses `almost_full` for back-pressure and the error flags for status reporting.

## Interface
- `DATA_WIDTH`, 68: word width in bits.
- `LOGDEPTH`, 7: log2 of depth; must be ≥ 2.
- `DEPTH`, 2**LOGDEPTH: number of entries; derived, never overridden.
- `AFULL_THRESH`, DEPTH-4: `almost_full` asserts when count ≥ this value; range 1..DEPTH.
- `AEMPTY_THRESH`, 4: `almost_empty` asserts when count ≤ this value; range 0..DEPTH-1.
- `FWFT`, 1: 1 selects first-word-fall-through; 0 selects standard mode with one-cycle read latency.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: write request.
- `din` input DATA_WIDTH: write data.
- `rd_en` input 1: read request, or pop in FWFT mode.
- `clear_flags` input 1: clears `overflow` and `underflow`.
- `dout` output DATA_WIDTH: read data.
- `empty` output 1: no entries stored.
- `full` output 1: DEPTH entries stored.
- `almost_empty` output 1: count ≤ AEMPTY_THRESH.
- `almost_full` output 1: count ≥ AFULL_THRESH.
- `count` output LOGDEPTH+1: occupancy, 0..DEPTH.
- `overflow` output 1: sticky; a write was attempted while full.
- `underflow` output 1: sticky; a read was attempted while empty.

## Operation
- **Pointers.** Write and read pointers are binary, LOGDEPTH bits wide, and wrap DEPTH-1 → 0. No Gray coding is used. `count` is held in its own LOGDEPTH+1-bit register.
- **Accept rules.**
  - A write is accepted when `wr_en` and not `full`.
  - A read is accepted when `rd_en` and not `empty`.
  - Rejected requests change no state except the error flags.
- **Count update.**
  - Accepted write with no accepted read: +1.
  - Accepted read with no accepted write: −1.
  - Both accepted, or neither: unchanged.
- **Simultaneous write and read.**
  - When not empty and not full: both are accepted, `count` holds, and the pointers advance.
  - When full: the read is accepted and the write is rejected, setting `overflow`. There is no pass-through.
  - When empty: the write is accepted and the read is rejected, setting `underflow`. Written data never bypasses storage.
- **Flags.**
  - `empty`, `full`, `almost_empty` and `almost_full` are registered. They are computed from the next value of `count`, so they always agree with `count`.
- **Error flags.**
  - `overflow` sets on `wr_en` & `full`.
  - `underflow` sets on `rd_en` & `empty`.
  - Both hold until `clear_flags` or `rst`.
  - If `clear_flags` and a new error event occur in the same cycle, set wins.
- **FWFT=1.**
  - `dout` = mem[rd_ptr] whenever not `empty`, and 0 while `empty`.
  - `rd_en` pops the head entry. The next entry appears on `dout` after the edge.
- **FWFT=0.**
  - `dout` is a register loaded with mem[rd_ptr] on an accepted read.
  - `dout` holds its value on cycles with no accepted read, including rejected reads.
- **Memory contents.** Storage is not cleared by `rst`; only the pointers, `count`, flags and `dout` reset.

## Timing
- **Reset values**, one edge after `rst` is high:
  - `count` = 0, `empty` = 1, `full` = 0.
  - `almost_empty` = 1, `almost_full` = 0.
  - `overflow` = 0, `underflow` = 0, `dout` = 0.
- **Reset priority.** `rst` has priority over every input in the same cycle. A reset mid-burst discards all stored entries.
- **Write to visible.**
  - Write accepted at edge n: `count`, `empty` and `full` reflect it after edge n.
  - In FWFT mode, when the FIFO was empty, `dout` shows the word after edge n (1-cycle latency).
- **Read latency.**
  - FWFT=0: read accepted at edge n → `dout` valid after edge n.
  - FWFT=1: the head word is already present before the pop.
- **Throughput.** Sustained 1 write and 1 read per cycle when neither empty nor full.
- **Wrap-around.** Pointer wrap is transparent. `count` is the sole source of the full/empty decision.

## Structure
- **Package `fifo_pkg`:**
  - function `clog2_safe`;
  - typedef `fifo_status_t`: a packed struct of empty, full, almost_empty, almost_full, overflow, underflow, for status-register mapping.
- **Sub-module `fifo_ram_sdp`:** simple dual-port RAM with one clock.
  - Write port is synchronous.
  - Read port is asynchronous for FWFT=1 and synchronous for FWFT=0.
  - Parameters: DATA_WIDTH and DEPTH.
- **Top level:** pointers, count, flag registers and error logic.

## Test plan
- Reset, then write 0x1..0x80 (128 words, LOGDEPTH=7) → `full` = 1 after the 128th edge. Then pop all → data in order 0x1..0x80, `empty` = 1, `count` = 0.
- With `full` = 1, assert `wr_en` with din = 0xDEAD → `count` stays 128, `overflow` = 1, no data corruption. Pulse `clear_flags` → `overflow` = 0.
- With `empty` = 1, assert `rd_en` and `wr_en` together with din = 0x5 → `underflow` = 1, `count` = 1. FWFT: `dout` = 0x5 next cycle.
- Hold `count` = 60 and run 200 cycles of simultaneous writes and reads crossing pointer wrap → `count` = 60 throughout, output order preserved, `full` and `empty` never assert.
- With AFULL_THRESH = 124 and AEMPTY_THRESH = 4, fill from 0 → `almost_empty` deasserts at count 5 and `almost_full` asserts at count 124. Assert `rst` at count 90 → all outputs at reset values next cycle.
- With FWFT = 0, write 0xA and 0xB, then issue a read → `dout` = 0xA one cycle after the read edge. With `rd_en` low, `dout` holds 0xA.
